bus_arbiter: RTL and testbench
==============================

// Module: bus_arbiter
// PURPOSE
//   Shares the single system bus (imem/dmem/UART/GPIO/timer map) between two masters:
//   M0 = instruction fetch (read-only), M1 = load/store unit. Round-robin grant, one
//   outstanding transaction, decode-error, write-protect and timeout responses.
//   Sits between the core's fetch/LSU ports and address_decoder + slave mux.
// PARAMETERS
//   ADDR_W         32  address width
//   DATA_W         32  data width
//   TIMEOUT        16  max cycles in ACCESS without s_ready before error (>=2)
//   IMEM_WPROTECT  1   1 = M1 writes hitting imem region are rejected with error
// PORTS
//   clk         in   1       system clock, rising edge
//   rst_n       in   1       async active-low reset
//   m0_req      in   1       fetch request (level; sampled only in IDLE)
//   m0_addr     in   ADDR_W  fetch address
//   m0_ack      out  1       1-cycle pulse: response valid
//   m0_rdata    out  DATA_W  read data, valid with m0_ack
//   m0_err      out  1       error flag, valid with m0_ack
//   m1_req      in   1       LSU request
//   m1_we       in   1       1 = write
//   m1_addr     in   ADDR_W  LSU address
//   m1_wdata    in   DATA_W  write data
//   m1_be       in   4       byte enables
//   m1_ack      out  1       1-cycle pulse: response valid
//   m1_rdata    out  DATA_W  read data (0 on write/error)
//   m1_err      out  1       error flag, valid with m1_ack
//   s_req       out  1       slave access strobe, held until s_ready
//   s_we/s_addr/s_wdata/s_be out  1/ADDR_W/DATA_W/4  latched transaction
//   s_rdata     in   DATA_W  slave read data, valid with s_ready
//   s_ready     in   1       slave completion
//   s_hit       in   1       from address_decoder: s_addr in any mapped region
//   s_sel_imem  in   1       from address_decoder: s_addr in imem region
// BEHAVIOUR
//   - Reset (async, any state): state=IDLE, last_grant=M1, all outputs 0, latched
//     fields 0, timeout count 0; in-flight transaction dropped, no ack issued.
//   - IDLE: if any req, grant + latch addr/we/wdata/be (M0: we=0, be=4'hF) -> ACCESS.
//     Both req: grant the master != last_grant (first tie after reset -> M0).
//   - ACCESS: s_addr/s_we/s_wdata/s_be drive latched values. access_ok = s_hit &&
//     !(IMEM_WPROTECT && s_we && s_sel_imem). s_req = ACCESS && access_ok (comb).
//     !access_ok on first ACCESS cycle -> RESP with err=1; s_req never asserted.
//     s_ready=1 -> capture s_rdata (0 if write), err=0 -> RESP.
//     count reaches TIMEOUT-1 with s_ready=0 -> RESP, err=1. s_ready on that same
//     cycle wins (err=0).
//   - RESP: granted mN_ack=1 for exactly one cycle with rdata/err registered;
//     last_grant updated; -> IDLE. Other master's ack stays 0.
//   - Min latency: req seen in IDLE cycle N, s_ready in N+1 -> ack in N+2.
//     Back-to-back: next grant earliest cycle N+3.
//   - Requests changing after grant are ignored until the next IDLE; master drops
//     req on its ack or the request is re-granted.
//   - s_ready outside ACCESS ignored. mN_rdata/err hold last value, qualified by ack.
// STRUCTURE
//   - bus_defs.vh (shared): state encodings IDLE/ACCESS/RESP, master IDs M0/M1,
//     memory-map base/limit constants shared with address_decoder.
//   - Sub-module bus_timeout_ctr: clear/enable/expire counter, width $clog2(TIMEOUT).
//   - Remainder: 3-state FSM, grant/latch registers, response registers.
// TESTING
//   1 M0 read 0x0000_0010, slave ready next cycle rdata=0xDEAD_BEEF -> m0_ack at N+2,
//     m0_rdata=0xDEADBEEF, m0_err=0.
//   2 M0+M1 req same cycle after reset -> M0 served first, then M1; repeat -> alternates.
//   3 M1 write 0x0000_5000 data 0x1234_5678 be=4'b0011 -> s_we=1, s_be=3, m1_ack err=0.
//   4 M1 write 0x0000_0100 (imem) -> s_req never high, m1_ack with err=1; with
//     IMEM_WPROTECT=0 write reaches slave.
//   5 M1 read 0x0000_7000 (unmapped, s_hit=0) -> err=1, no s_req; slave never ready
//     at 0x0000_8000 -> err=1 after TIMEOUT cycles; ready on last cycle -> err=0.
//   6 rst_n low mid-ACCESS -> all outputs 0 immediately, no ack; next req granted.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the two-master system bus arbiter: FSM states, master IDs
// and the memory map shared with the address decoder.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } state_e;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } master_e;

  localparam logic [31:0] ImemBase  = 32'h0000_0000;
  localparam logic [31:0] ImemLimit = 32'h0000_3FFF;
  localparam logic [31:0] DmemBase  = 32'h0000_4000;
  localparam logic [31:0] DmemLimit = 32'h0000_5FFF;
  localparam logic [31:0] UartBase  = 32'h0000_8000;
  localparam logic [31:0] UartLimit = 32'h0000_80FF;
  localparam logic [31:0] GpioBase  = 32'h0000_8100;
  localparam logic [31:0] GpioLimit = 32'h0000_81FF;
  localparam logic [31:0] TimerBase = 32'h0000_8200;
  localparam logic [31:0] TimerLimit = 32'h0000_82FF;

  function automatic logic in_region(input logic [31:0] addr, input logic [31:0] base,
                                     input logic [31:0] limit);
    return (addr >= base) && (addr <= limit);
  endfunction

endpackage

// File: rtl/bus_timeout_ctr.sv
// Access watchdog: counts cycles while enabled and flags the last allowed cycle.
module bus_timeout_ctr #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign expire = enable && (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expire) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing the system bus between instruction fetch (M0) and the
// load/store unit (M1), with one outstanding transaction and error responses.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned TIMEOUT       = 16,
  parameter int unsigned IMEM_WPROTECT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [3:0]        m1_be,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic              s_req,
  output logic              s_we,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  output logic [3:0]        s_be,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              s_ready,
  input  logic              s_hit,
  input  logic              s_sel_imem
);

  state_e            state_q, state_d;
  master_e           grant_q, grant_d;
  master_e           last_grant_q, last_grant_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
  logic              m0_err_q, m0_err_d, m1_err_q, m1_err_d;
  logic              access_ok, expire;
  logic              rsp_valid, rsp_err;
  logic [DATA_W-1:0] rsp_data;

  assign access_ok = s_hit && !((IMEM_WPROTECT != 0) && we_q && s_sel_imem);

  bus_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state_q != StAccess),
    .enable(state_q == StAccess),
    .expire(expire)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    m0_rdata_d   = m0_rdata_q;
    m0_err_d     = m0_err_q;
    m1_rdata_d   = m1_rdata_q;
    m1_err_d     = m1_err_q;
    rsp_valid    = 1'b0;
    rsp_err      = 1'b0;
    rsp_data     = '0;

    unique case (state_q)
      StIdle: begin
        if (m0_req || m1_req) begin
          if (m0_req && m1_req) begin
            grant_d = (last_grant_q == M0) ? M1 : M0;
          end else begin
            grant_d = m1_req ? M1 : M0;
          end
          if (grant_d == M1) begin
            we_d    = m1_we;
            addr_d  = m1_addr;
            wdata_d = m1_wdata;
            be_d    = m1_be;
          end else begin
            we_d    = 1'b0;
            addr_d  = m0_addr;
            wdata_d = '0;
            be_d    = 4'hF;
          end
          state_d = StAccess;
        end
      end
      StAccess: begin
        // Decode/protect errors never reach the slave; ready beats a same-cycle expiry.
        if (!access_ok) begin
          rsp_valid = 1'b1;
          rsp_err   = 1'b1;
        end else if (s_ready) begin
          rsp_valid = 1'b1;
          rsp_data  = we_q ? '0 : s_rdata;
        end else if (expire) begin
          rsp_valid = 1'b1;
          rsp_err   = 1'b1;
        end
      end
      StResp: begin
        last_grant_d = grant_q;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (rsp_valid) begin
      state_d = StResp;
      if (grant_q == M1) begin
        m1_rdata_d = rsp_data;
        m1_err_d   = rsp_err;
      end else begin
        m0_rdata_d = rsp_data;
        m0_err_d   = rsp_err;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      grant_q      <= M0;
      last_grant_q <= M1;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      m0_rdata_q   <= '0;
      m0_err_q     <= 1'b0;
      m1_rdata_q   <= '0;
      m1_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      m0_rdata_q   <= m0_rdata_d;
      m0_err_q     <= m0_err_d;
      m1_rdata_q   <= m1_rdata_d;
      m1_err_q     <= m1_err_d;
    end
  end

  assign m0_ack   = (state_q == StResp) && (grant_q == M0);
  assign m1_ack   = (state_q == StResp) && (grant_q == M1);
  assign m0_rdata = m0_rdata_q;
  assign m0_err   = m0_err_q;
  assign m1_rdata = m1_rdata_q;
  assign m1_err   = m1_err_q;
  assign s_req    = (state_q == StAccess) && access_ok;
  assign s_we     = we_q;
  assign s_addr   = addr_q;
  assign s_wdata  = wdata_q;
  assign s_be     = be_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: a write-protected and an unprotected instance share
// stimulus; the address decoder is modelled locally from the memory map.
module tb_bus_arbiter;

  localparam int unsigned TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_req, m1_req, m1_we, s_ready;
  logic [31:0] m0_addr, m1_addr, m1_wdata, s_rdata;
  logic [3:0]  m1_be;

  logic        m0_ack, m0_err, m1_ack, m1_err, s_req, s_we, s_hit, s_sel_imem;
  logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
  logic [3:0]  s_be;

  logic        np_m0_ack, np_m0_err, np_m1_ack, np_m1_err, np_s_req, np_s_we;
  logic        np_s_hit, np_s_sel_imem;
  logic [31:0] np_m0_rdata, np_m1_rdata, np_s_addr, np_s_wdata;
  logic [3:0]  np_s_be;

  int n_cmp = 0;
  int n_err = 0;
  int cyc;

  always #5 clk = ~clk;

  function automatic logic dec_hit(input logic [31:0] a);
    return (a < 32'h0000_6000) || ((a >= 32'h0000_8000) && (a < 32'h0000_8300));
  endfunction

  function automatic logic dec_imem(input logic [31:0] a);
    return a < 32'h0000_4000;
  endfunction

  assign s_hit         = dec_hit(s_addr);
  assign s_sel_imem    = dec_imem(s_addr);
  assign np_s_hit      = dec_hit(np_s_addr);
  assign np_s_sel_imem = dec_imem(np_s_addr);

  bus_arbiter #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT), .IMEM_WPROTECT(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata), .s_be(s_be),
    .s_rdata(s_rdata), .s_ready(s_ready), .s_hit(s_hit), .s_sel_imem(s_sel_imem)
  );

  bus_arbiter #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT), .IMEM_WPROTECT(0)
  ) dut_np (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_ack(np_m0_ack), .m0_rdata(np_m0_rdata),
    .m0_err(np_m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
    .m1_ack(np_m1_ack), .m1_rdata(np_m1_rdata), .m1_err(np_m1_err),
    .s_req(np_s_req), .s_we(np_s_we), .s_addr(np_s_addr), .s_wdata(np_s_wdata),
    .s_be(np_s_be), .s_rdata(s_rdata), .s_ready(s_ready), .s_hit(np_s_hit),
    .s_sel_imem(np_s_sel_imem)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Slave completes the current access this cycle; returns one cycle later.
  task automatic serve(input logic [31:0] rdata);
    s_ready = 1'b1;
    s_rdata = rdata;
    tick();
    s_ready = 1'b0;
    s_rdata = '0;
  endtask

  task automatic wait_m1_ack(input int budget, output int cycles);
    cycles = 0;
    while (!m1_ack && cycles < budget) begin
      tick();
      cycles++;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ctl"}, {24'd0, m0_ack, m0_err, m1_ack, m1_err, s_req, s_we, np_s_req,
                             np_m1_ack}, 32'd0);
    check_eq({tag, "_sbe"}, {28'd0, s_be}, 32'd0);
    check_eq({tag, "_saddr"}, s_addr, 32'd0);
    check_eq({tag, "_swdata"}, s_wdata, 32'd0);
    check_eq({tag, "_m0rd"}, m0_rdata, 32'd0);
    check_eq({tag, "_m1rd"}, m1_rdata, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  initial begin
    m0_req = 0; m1_req = 0; m1_we = 0; s_ready = 0;
    m0_addr = '0; m1_addr = '0; m1_wdata = '0; s_rdata = '0; m1_be = '0;

    // Reset state
    #2;
    check_all_zero("rst");
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // 1: M0 read, minimum latency
    m0_req = 1; m0_addr = 32'h0000_0010;
    tick();
    check_eq("t1_sreq", s_req, 1);
    check_eq("t1_saddr", s_addr, 32'h0000_0010);
    check_eq("t1_swe", s_we, 0);
    check_eq("t1_sbe", s_be, 4'hF);
    check_eq("t1_early_ack", m0_ack, 0);
    m0_req = 0;
    serve(32'hDEAD_BEEF);
    check_eq("t1_ack", m0_ack, 1);
    check_eq("t1_rdata", m0_rdata, 32'hDEAD_BEEF);
    check_eq("t1_err", m0_err, 0);
    check_eq("t1_m1ack", m1_ack, 0);
    tick();
    check_eq("t1_ack_pulse", m0_ack, 0);
    check_eq("t1_rdata_hold", m0_rdata, 32'hDEAD_BEEF);

    // 2: round-robin starting from a fresh reset
    rst_n = 0;
    tick();
    rst_n = 1;
    m0_req = 1; m0_addr = 32'h0000_0020;
    m1_req = 1; m1_we = 0; m1_addr = 32'h0000_4000; m1_be = 4'hF;
    tick();
    check_eq("t2_first_m0", s_addr, 32'h0000_0020);
    serve(32'h1111_1111);
    check_eq("t2_m0ack", m0_ack, 1);
    check_eq("t2_m1ack0", m1_ack, 0);
    m0_req = 0;
    tick();
    tick();
    check_eq("t2_then_m1", s_addr, 32'h0000_4000);
    serve(32'h2222_2222);
    check_eq("t2_m1ack", m1_ack, 1);
    check_eq("t2_m1rdata", m1_rdata, 32'h2222_2222);
    check_eq("t2_m0ack0", m0_ack, 0);
    m0_req = 1;
    tick();
    tick();
    check_eq("t2_alt_m0", s_addr, 32'h0000_0020);
    serve(32'h3333_3333);
    check_eq("t2_alt_m0ack", m0_ack, 1);
    m0_req = 0;
    tick();
    tick();
    check_eq("t2_alt_m1", s_addr, 32'h0000_4000);
    serve(32'h4444_4444);
    check_eq("t2_alt_m1ack", m1_ack, 1);
    m1_req = 0;
    tick();

    // 3: M1 partial write
    m1_req = 1; m1_we = 1; m1_addr = 32'h0000_5000; m1_wdata = 32'h1234_5678; m1_be = 4'b0011;
    tick();
    check_eq("t3_sreq", s_req, 1);
    check_eq("t3_swe", s_we, 1);
    check_eq("t3_sbe", s_be, 4'b0011);
    check_eq("t3_swdata", s_wdata, 32'h1234_5678);
    check_eq("t3_saddr", s_addr, 32'h0000_5000);
    m1_req = 0; m1_we = 0;
    serve(32'hFFFF_FFFF);
    check_eq("t3_ack", m1_ack, 1);
    check_eq("t3_err", m1_err, 0);
    check_eq("t3_rdata_zero", m1_rdata, 32'd0);
    tick();

    // 4: write into imem, protected vs unprotected
    m1_req = 1; m1_we = 1; m1_addr = 32'h0000_0100; m1_wdata = 32'h0000_AAAA; m1_be = 4'hF;
    tick();
    check_eq("t4_wp_sreq", s_req, 0);
    check_eq("t4_np_sreq", np_s_req, 1);
    m1_req = 0; m1_we = 0;
    tick();
    check_eq("t4_wp_ack", m1_ack, 1);
    check_eq("t4_wp_err", m1_err, 1);
    check_eq("t4_wp_sreq2", s_req, 0);
    check_eq("t4_np_wait", np_m1_ack, 0);
    serve(32'h5555_5555);
    check_eq("t4_np_ack", np_m1_ack, 1);
    check_eq("t4_np_err", np_m1_err, 0);
    check_eq("t4_wp_ack_pulse", m1_ack, 0);
    tick();

    // 5a: unmapped read
    m1_req = 1; m1_we = 0; m1_addr = 32'h0000_7000;
    tick();
    check_eq("t5a_sreq", s_req, 0);
    m1_req = 0;
    tick();
    check_eq("t5a_ack", m1_ack, 1);
    check_eq("t5a_err", m1_err, 1);
    tick();

    // 5b: slave never ready -> timeout after TIMEOUT access cycles
    m1_req = 1; m1_addr = 32'h0000_8000;
    tick();
    check_eq("t5b_sreq", s_req, 1);
    m1_req = 0;
    wait_m1_ack(40, cyc);
    check_eq("t5b_latency", cyc, TIMEOUT);
    check_eq("t5b_err", m1_err, 1);
    check_eq("t5b_rdata", m1_rdata, 32'd0);
    tick();

    // 5c: ready on the last allowed cycle wins over timeout
    m1_req = 1;
    tick();
    m1_req = 0;
    for (int i = 0; i < int'(TIMEOUT) - 1; i++) tick();
    check_eq("t5c_no_early_ack", m1_ack, 0);
    check_eq("t5c_sreq_last", s_req, 1);
    serve(32'hCAFE_F00D);
    check_eq("t5c_ack", m1_ack, 1);
    check_eq("t5c_err", m1_err, 0);
    check_eq("t5c_rdata", m1_rdata, 32'hCAFE_F00D);
    tick();

    // 6: reset mid-access
    m0_req = 1; m0_addr = 32'h0000_0010;
    tick();
    check_eq("t6_sreq", s_req, 1);
    rst_n = 0;
    #1;
    check_all_zero("t6_rst");
    tick();
    check_eq("t6_noack", m0_ack, 0);
    tick();
    check_eq("t6_noack2", m0_ack, 0);
    rst_n = 1;
    tick();
    check_eq("t6_regrant", s_addr, 32'h0000_0010);
    check_eq("t6_regrant_sreq", s_req, 1);
    m0_req = 0;
    serve(32'h0000_600D);
    check_eq("t6_ack", m0_ack, 1);
    check_eq("t6_rdata", m0_rdata, 32'h0000_600D);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
